// File: rtl/cla_pipe_adder_if.sv
// Operand/result bundle for the pipelined CLA adder.
// Both directions use valid/ready: a beat moves on a rising edge where valid and ready are both high.
interface cla_pipe_adder_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/cla_pipe_adder.sv
// Two-stage carry-lookahead adder/subtractor.
// Stage 1 registers the bit and group generate/propagate terms. Stage 2 resolves the carries and registers sum, cout and ovf.
module cla_pipe_adder #(
  parameter int WIDTH = 16,
  parameter int GROUP = 4
) (
  input logic           clk,
  input logic           rst_n,
  cla_pipe_adder_if.slave bus
);
  localparam int NG = WIDTH / GROUP;

  if ((GROUP < 1) || (WIDTH % GROUP != 0)) begin : g_bad_cfg
    $error("cla_pipe_adder: WIDTH must be a non-zero multiple of GROUP");
  end

  // Pipeline control
  logic s1_valid_q, s1_valid_d;
  logic out_valid_q, out_valid_d;
  logic s2_adv, s1_load, in_xfer;

  assign s2_adv  = !out_valid_q || bus.out_ready;
  assign s1_load = !s1_valid_q || s2_adv;
  assign in_xfer = bus.in_valid && s1_load;

  always_comb begin
    s1_valid_d  = s1_valid_q;
    out_valid_d = out_valid_q;
    if (s1_load) s1_valid_d = bus.in_valid;
    if (s2_adv)  out_valid_d = s1_valid_q;
  end

  // Stage 1: operand conditioning and generate/propagate terms
  logic [WIDTH-1:0] b_eff, p_d, g_d;
  logic [NG-1:0]    gp_d, gg_d;
  logic             c0_d;

  always_comb begin
    logic pacc, gacc;
    b_eff = bus.sub ? ~bus.b : bus.b;
    c0_d  = bus.sub | bus.cin;
    p_d   = bus.a ^ b_eff;
    g_d   = bus.a & b_eff;
    gp_d  = '0;
    gg_d  = '0;
    for (int k = 0; k < NG; k++) begin
      pacc = 1'b1;
      gacc = 1'b0;
      for (int j = 0; j < GROUP; j++) begin
        gacc = g_d[k*GROUP+j] | (p_d[k*GROUP+j] & gacc);
        pacc = pacc & p_d[k*GROUP+j];
      end
      gp_d[k] = pacc;
      gg_d[k] = gacc;
    end
  end

  logic [WIDTH-1:0] p_q, g_q;
  logic [NG-1:0]    gp_q, gg_q;
  logic             c0_q, a_msb_q, b_msb_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      p_q        <= '0;
      g_q        <= '0;
      gp_q       <= '0;
      gg_q       <= '0;
      c0_q       <= 1'b0;
      a_msb_q    <= 1'b0;
      b_msb_q    <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      if (in_xfer) begin
        p_q     <= p_d;
        g_q     <= g_d;
        gp_q    <= gp_d;
        gg_q    <= gg_d;
        c0_q    <= c0_d;
        a_msb_q <= bus.a[WIDTH-1];
        b_msb_q <= b_eff[WIDTH-1];
      end
    end
  end

  // Stage 2: group carries ripple between groups; each bit carry is a lookahead from its group carry-in
  logic [NG:0]      cg;
  logic [WIDTH-1:0] cb, sum_d;
  logic             cout_d, ovf_d;

  always_comb begin
    logic pp, pg;
    cg    = '0;
    cb    = '0;
    cg[0] = c0_q;
    for (int k = 0; k < NG; k++) begin
      cg[k+1] = gg_q[k] | (gp_q[k] & cg[k]);
    end
    for (int k = 0; k < NG; k++) begin
      pp = 1'b1;
      pg = 1'b0;
      for (int j = 0; j < GROUP; j++) begin
        cb[k*GROUP+j] = pg | (pp & cg[k]);
        pg = g_q[k*GROUP+j] | (p_q[k*GROUP+j] & pg);
        pp = pp & p_q[k*GROUP+j];
      end
    end
    sum_d  = p_q ^ cb;
    cout_d = cg[NG];
    ovf_d  = (a_msb_q == b_msb_q) && (sum_d[WIDTH-1] != a_msb_q);
  end

  logic [WIDTH-1:0] sum_q;
  logic             cout_q, ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      if (s2_adv && s1_valid_q) begin
        sum_q  <= sum_d;
        cout_q <= cout_d;
        ovf_q  <= ovf_d;
      end
    end
  end

  assign bus.in_ready  = s1_load;
  assign bus.out_valid = out_valid_q;
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_cla_pipe_adder.sv
// Bench for cla_pipe_adder. Three copies (GROUP = 4, 2, 8) run in lockstep on shared stimulus.
// One scoreboard checks all three copies against an arithmetic reference.
module tb_cla_pipe_adder;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic cin = 1'b0;
  logic sub = 1'b0;
  logic out_ready = 1'b1;

  logic [2:0]   ov, ir, co, of;
  logic [W-1:0] sm [3];

  always #5 clk = ~clk;

  for (genvar k = 0; k < 3; k++) begin : g_dut
    localparam int GRP = (k == 0) ? 4 : ((k == 1) ? 2 : 8);
    cla_pipe_adder_if #(.WIDTH(W)) bus_if ();
    cla_pipe_adder #(.WIDTH(W), .GROUP(GRP)) u_dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus_if)
    );
    assign bus_if.in_valid  = in_valid;
    assign bus_if.a         = a;
    assign bus_if.b         = b;
    assign bus_if.cin       = cin;
    assign bus_if.sub       = sub;
    assign bus_if.out_ready = out_ready;
    assign ov[k] = bus_if.out_valid;
    assign ir[k] = bus_if.in_ready;
    assign co[k] = bus_if.cout;
    assign of[k] = bus_if.ovf;
    assign sm[k] = bus_if.sum;
  end

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int n_acc = 0;
  int n_out = 0;
  bit lat_mode = 1'b1;
  bit hold_check = 1'b0;

  logic [W+1:0] exp_q [$];
  int           cyc_q [$];

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: plain integer arithmetic; result packed as {cout, ovf, sum}
  function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic ci, input logic sb);
    int ux, uy, sx, sy, u, s;
    logic c, v;
    logic [W-1:0] r;
    ux = int'(x);
    uy = int'(y);
    sx = int'($signed(x));
    sy = int'($signed(y));
    if (sb) begin
      u = ux - uy;
      s = sx - sy;
      c = (ux >= uy);
    end else begin
      u = ux + uy + int'(ci);
      s = sx + sy + int'(ci);
      c = (u > 65535);
    end
    v = (s > 32767) || (s < -32768);
    r = u[W-1:0];
    return {c, v, r};
  endfunction

  // Scoreboard
  always @(negedge clk) begin
    logic [W+1:0] e;
    int c;
    if (rst_n) begin
      if (out_ready && ov[0]) begin
        if (exp_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL out_unexpected: out_valid with no pending result, sum=%h", sm[0]);
        end else begin
          e = exp_q.pop_front();
          c = cyc_q.pop_front();
          n_out++;
          for (int k = 0; k < 3; k++) begin
            n_chk++;
            if (!ov[k] || {co[k], of[k], sm[k]} !== e) begin
              n_fail++;
              $display("FAIL result[dut%0d]: got v=%b {cout,ovf,sum}=%h, expected %h", k, ov[k],
                       {co[k], of[k], sm[k]}, e);
            end
          end
          if (lat_mode) begin
            n_chk++;
            if (cyc - c != 2) begin
              n_fail++;
              $display("FAIL latency: got %0d cycles, expected 2", cyc - c);
            end
          end
        end
      end else if (out_ready && (ov[1] || ov[2])) begin
        n_chk++; n_fail++;
        $display("FAIL out_spurious: out_valid=%b, expected 000", ov);
      end
      if (hold_check && ov[0] && !out_ready && exp_q.size() > 0) begin
        for (int k = 0; k < 3; k++) begin
          n_chk++;
          if ({co[k], of[k], sm[k]} !== exp_q[0]) begin
            n_fail++;
            $display("FAIL hold[dut%0d]: got %h, expected %h", k, {co[k], of[k], sm[k]}, exp_q[0]);
          end
        end
      end
      if (in_valid && ir[0]) begin
        exp_q.push_back(model(a, b, cin, sub));
        cyc_q.push_back(cyc);
        n_acc++;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
    n_chk++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, got, expv);
    end
  endtask

  task automatic drain();
    for (int t = 0; t < 40 && exp_q.size() != 0; t++) @(posedge clk);
    #1;
    check("drain_empty", exp_q.size(), 0);
  endtask

  task automatic rand_operands();
    a   = W'($urandom_range(0, 65535));
    b   = W'($urandom_range(0, 65535));
    cin = 1'($urandom_range(0, 1));
    sub = 1'($urandom_range(0, 1));
  endtask

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } vec_t;

  vec_t vt [12];

  initial begin
    int acc0, out0;
    bit got, took;

    vt[0]  = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    vt[1]  = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    vt[2]  = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    vt[3]  = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vt[4]  = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vt[5]  = '{16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0};
    vt[6]  = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};
    vt[7]  = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
    vt[8]  = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};
    vt[9]  = '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
    vt[10] = '{16'h0000, 16'h8000, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1};
    vt[11] = '{16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("rst_out_valid[%0d]", k), ov[k], 0);
      check($sformatf("rst_sum[%0d]", k), sm[k], 0);
      check($sformatf("rst_cout_ovf[%0d]", k), {co[k], of[k]}, 0);
      check($sformatf("rst_in_ready[%0d]", k), ir[k], 1);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed vectors, one at a time
    for (int i = 0; i < 12; i++) begin
      a = vt[i].a; b = vt[i].b; cin = vt[i].cin; sub = vt[i].sub;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      got = 1'b0;
      for (int t = 0; t < 6 && !got; t++) begin
        @(negedge clk);
        if (ov[0]) got = 1'b1;
      end
      check($sformatf("vec%0d_valid", i), got, 1);
      for (int k = 0; k < 3; k++)
        check($sformatf("vec%0d[dut%0d]", i, k), {co[k], of[k], sm[k]},
              {vt[i].cout, vt[i].ovf, vt[i].sum});
      @(posedge clk); #1;
    end

    // 100 back-to-back random pairs, out_ready held high
    out0 = n_out;
    for (int i = 0; i < 100; i++) begin
      rand_operands();
      in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    drain();
    check("b2b_count", n_out - out0, 100);

    // Backpressure: out_ready low for 5 cycles with in_valid high
    lat_mode = 1'b0;
    hold_check = 1'b1;
    out_ready = 1'b0;
    acc0 = n_acc;
    out0 = n_out;
    rand_operands();
    in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      took = ir[0];
      @(posedge clk); #1;
      if (took) rand_operands();
    end
    @(negedge clk);
    check("bp_accepted", n_acc - acc0, 2);
    check("bp_in_ready", ir, 3'b000);
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    hold_check = 1'b0;
    drain();
    check("bp_released", n_out - out0, 2);

    // Random valid/ready on both sides, including full-pipe simultaneous transfers
    acc0 = n_acc;
    out0 = n_out;
    rand_operands();
    for (int c = 0; c < 300; c++) begin
      in_valid  = 1'($urandom_range(0, 3) != 0);
      out_ready = 1'($urandom_range(0, 2) != 0);
      @(negedge clk);
      took = in_valid && ir[0];
      @(posedge clk); #1;
      if (took) rand_operands();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain();
    check("rand_conserved", n_out - out0, n_acc - acc0);

    // Asynchronous reset with two results in flight
    lat_mode = 1'b1;
    rand_operands();
    in_valid = 1'b1;
    @(posedge clk); #1;
    rand_operands();
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("pre_rst_valid", ov[0], 1);
    #1;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    cyc_q.delete();
    for (int k = 0; k < 3; k++) begin
      check($sformatf("async_rst_valid[%0d]", k), ov[k], 0);
      check($sformatf("async_rst_sum[%0d]", k), sm[k], 0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("post_rst_no_valid", ov, 3'b000);
      check("post_rst_in_ready", ir, 3'b111);
    end
    @(posedge clk); #1;
    a = 16'h00FF; b = 16'h0001; cin = 1'b0; sub = 1'b0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/cla_pipe_adder.md
# cla_pipe_adder

Parametrised, two-stage pipelined carry-lookahead adder/subtractor built from per-bit generate/propagate cells and per-group lookahead carry logic. Accepts one operand pair per cycle over a valid/ready handshake and returns sum, carry-out and signed overflow two cycles later. Sits in the datapath as the shared add/sub unit feeding the ALU result mux. It is the multi-bit, pipelined successor to the single-bit carry cell (cout = g | p & cin).

## Interface
- WIDTH, 16, operand and sum width in bits; must be a multiple of GROUP (elaboration error otherwise)
- GROUP, 4, bits per lookahead group; WIDTH/GROUP groups total
- clk  input  1  rising-edge clock
- rst_n  input  1  reset; one clock; reset is asynchronous and active-low
- in_valid  input  1  operand pair present
- in_ready  output  1  adder can accept this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- cin  input  1  carry-in (ignored when sub=1)
- sub  input  1  0: a+b+cin; 1: a-b (a + ~b + 1)
- out_valid  output  1  result present
- out_ready  input  1  consumer accepts result
- sum  output  WIDTH  result
- cout  output  1  carry-out of MSB (for sub: 1 = no borrow)
- ovf  output  1  signed overflow

## Operation
- Input transfer when in_valid & in_ready; output transfer when out_valid & out_ready.
- Stage 1 (registered on input transfer): b_eff = sub ? ~b : b; c0 = sub ? 1 : cin; per bit p_i = a_i ^ b_eff_i, g_i = a_i & b_eff_i; per group P = AND of p, G = g[top] | p[top]&g[top-1] | ... (full lookahead within group). Registers: p, g, group P/G vectors, c0, a_msb, b_eff_msb, s1_valid.
- Stage 2 (registered on advance into stage 2): group carries c[k+1] = G[k] | P[k] & c[k] from c0 (ripple across groups); bit carries inside each group by lookahead from group carry-in; sum_i = p_i ^ c_i; cout = carry out of bit WIDTH-1; ovf = (a_msb == b_eff_msb) & (sum_msb != a_msb).
- Arithmetic modulo 2^WIDTH; no saturation.
- Pipeline control: s2 advances (loads from s1) when !out_valid | out_ready; s1 loads when !s1_valid | s2 advances. in_ready = !s1_valid | !out_valid | out_ready (combinational, no dependency on in_valid).
- s1_valid clears when s1 drains into s2 with no new input; out_valid clears on output transfer with no s1 data advancing.
- Stalled stages hold all registers unchanged (sum/cout/ovf stable while out_valid & !out_ready).

## Timing
- Reset (rst_n low, asynchronous): s1_valid=0, out_valid=0, sum=0, cout=0, ovf=0, all stage-1 registers 0; in_ready=1 once rst_n high with pipe empty.
- Latency: input transfer in cycle N -> out_valid=1 with result in cycle N+2.
- Throughput: one result per cycle with out_ready held high.
- Backpressure: out_ready low holds output; one further input is accepted into s1, then in_ready=0 until out_ready returns.
- Simultaneous output transfer and new input with full pipe: both occur same cycle, no bubble, no drop.
- Reset mid-operation: in-flight results discarded, no out_valid after rst_n release until new input.
- sum/cout/ovf are undefined-but-stable when out_valid=0; bench must not check them.

## Test plan
- WIDTH=16: a=0xFFFF, b=0x0001, cin=0, sub=0 -> two cycles later sum=0x0000, cout=1, ovf=0.
- a=0x7FFF, b=0x0001, sub=0 -> sum=0x8000, cout=0, ovf=1; a=0x8000, b=0x0001, sub=1 -> sum=0x7FFF, cout=1, ovf=1.
- a=0x0005, b=0x0007, sub=1 -> sum=0xFFFE, cout=0 (borrow), ovf=0; cin=1 with sub=1 gives identical result.
- 100 back-to-back random pairs, out_ready=1 -> 100 results in order, one per cycle, matching a+b+cin mod 2^16 against model; repeat with GROUP=2, 8.
- Hold out_ready=0 for 5 cycles with in_valid=1 -> exactly two pairs accepted, in_ready=0 afterward, sum stable; release -> results emerge in order, none lost or duplicated.
- Assert rst_n low for one cycle with two results in flight -> out_valid=0, sum=0 immediately (asynchronously); no stale result after release.
